// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the RV32M multiply/divide unit.
// Holds the funct3 encodings, the FSM state type, the datapath width and
// the iteration count used by both the shift-add and restoring loops.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement, purely combinational.
// Used to turn signed operands into magnitudes and to restore the sign of
// the product, quotient and remainder.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] fixed
);

    // negate by subtracting from zero when requested
    assign fixed = negate ? ({WIDTH{1'b0}} - value) : value;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiply is a 32-step shift-add on magnitudes; divide is a 32-step
// restoring division on magnitudes. Signs are applied at the end.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- when defined, rs2 == 0 and
// signed overflow finish straight from IDLE with a one-cycle latency.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start, outputs hold last result
// MUL     | one shift-add step per cycle, 32 cycles
// DIV     | one restoring step per cycle, 32 cycles
// DONE    | done/reg_write high for one cycle, back to IDLE
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write
);

    import muldiv_pkg::*;

    state_t       state;
    logic [5:0]   cnt;
    logic [63:0]  acc;
    logic [31:0]  opnd;
    logic [2:0]   op_q;
    logic [4:0]   rd_q;
    logic         neg_res;
    logic         neg_rem;
    logic         div_zero;

    logic         signed_a, signed_b;
    logic         neg_a, neg_b;
    logic [31:0]  mag_a, mag_b;

    logic [32:0]  mul_sum;
    logic [63:0]  mul_next;
    logic [33:0]  div_diff;
    logic         div_ok;
    logic [63:0]  div_next;
    logic [63:0]  prod_fix;
    logic [31:0]  quo_fix, rem_fix;
    logic [31:0]  mul_result, div_result;

    logic         early_hit;
    logic [31:0]  early_res;

    assign signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign neg_a    = signed_a & rs1[31];
    assign neg_b    = signed_b & rs2[31];

    muldiv_sign_fix #(.WIDTH(32)) u_fix_a (.value(rs1), .negate(neg_a), .fixed(mag_a));
    muldiv_sign_fix #(.WIDTH(32)) u_fix_b (.value(rs2), .negate(neg_b), .fixed(mag_b));

    // next accumulator values for one multiply step and one divide step
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        // partial remainder is 33 bits wide after the shift, so compare in 34
        div_diff = {1'b0, acc[63:31]} - {2'b00, opnd};
        div_ok   = ~|div_diff[33:32];
        div_next = div_ok ? {div_diff[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    end

    muldiv_sign_fix #(.WIDTH(64)) u_fix_prod (.value(mul_next),        .negate(neg_res), .fixed(prod_fix));
    muldiv_sign_fix #(.WIDTH(32)) u_fix_quo  (.value(div_next[31:0]),  .negate(neg_res), .fixed(quo_fix));
    muldiv_sign_fix #(.WIDTH(32)) u_fix_rem  (.value(div_next[63:32]), .negate(neg_rem), .fixed(rem_fix));

    // write-back selection from the final iteration; divide by zero forces all-ones quotient
    always_comb begin
        mul_result = (op_q == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];
        if (op_q[1])
            div_result = rem_fix;
        else if (div_zero)
            div_result = 32'hFFFF_FFFF;
        else
            div_result = quo_fix;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic ovf;
    assign ovf       = funct3[2] & ~funct3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    assign early_hit = (rs2 == 32'd0) | ovf;
    // result for operations that finish without iterating
    always_comb begin
        if (!funct3[2])
            early_res = 32'd0;
        else if (rs2 == 32'd0)
            early_res = funct3[1] ? rs1 : 32'hFFFF_FFFF;
        else
            early_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
`else
    assign early_hit = 1'b0;
    assign early_res = 32'd0;
`endif

    assign reg_write = done;

    // sequencing FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            rd_out   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q     <= funct3;
                        rd_q     <= rd_in;
                        busy     <= 1'b1;
                        neg_res  <= neg_a ^ neg_b;
                        neg_rem  <= neg_a;
                        div_zero <= (rs2 == 32'd0);
                        cnt      <= ITER_CNT;
                        if (early_hit) begin
                            result <= early_res;
                            rd_out <= rd_in;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else if (funct3[2]) begin
                            acc   <= {32'd0, mag_a};
                            opnd  <= mag_b;
                            state <= ST_DIV;
                        end else begin
                            acc   <= {32'd0, mag_b};
                            opnd  <= mag_a;
                            state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        result <= mul_result;
                        rd_out <= rd_q;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    acc <= div_next;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        result <= div_result;
                        rd_out <= rd_q;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit with a reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done, reg_write;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out), .reg_write(reg_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb, sq;
        sa = a;
        sb = b;
        p  = 64'd0;
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sq = sa / sb; return sq;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sq = sa % sb; return sq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (b == 0) return 1;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
        return 33 + 0 * int'(f3) + 0 * int'(a[0]);
    endfunction

    // reference model: tracks outstanding operation and held outputs
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = 32'd0, m_hold_res = 32'd0;
    logic [4:0]  m_rd = 5'd0, m_hold_rd = 5'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_left = 0; m_hold_res = 32'd0; m_hold_rd = 5'd0;
        end else if (m_busy) begin
            if (m_left == 0) m_busy = 1'b0;
            else begin
                m_left--;
                if (m_left == 0) begin m_hold_res = m_res; m_hold_rd = m_rd; end
            end
        end else if (start) begin
            m_res  = model_res(funct3, rs1, rs2);
            m_rd   = rd_in;
            m_busy = 1'b1;
            m_left = exp_lat(funct3, rs1, rs2) - 1;
            if (m_left == 0) begin m_hold_res = m_res; m_hold_rd = m_rd; end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (reset) begin
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_reg_write", {31'd0, reg_write}, 32'd0);
            check("rst_result", result, 32'd0);
            check("rst_rd_out", {27'd0, rd_out}, 32'd0);
        end else begin
            check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
            check("cyc_done", {31'd0, done}, {31'd0, (m_busy && m_left == 0)});
            check("cyc_reg_write", {31'd0, reg_write}, {31'd0, (m_busy && m_left == 0)});
            check("cyc_result", result, m_hold_res);
            check("cyc_rd_out", {27'd0, rd_out}, {27'd0, m_hold_rd});
        end
    end

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res);
        int cyc;
        check({name, "_model"}, model_res(f3, a, b), exp_res);
        @(negedge clk);
        start = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_in = rd;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
        while (!done && cyc < 100) begin
            start = (cyc == 5);
            if (cyc == 5) begin rs1 = $urandom; rs2 = $urandom; end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, "_latency"}, cyc, exp_lat(f3, a, b));
        check({name, "_result"}, result, exp_res);
        check({name, "_rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        check({name, "_reg_write"}, {31'd0, reg_write}, 32'd1);
        @(negedge clk);
        check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_done;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        run_op("mul_7x-3",      3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
        run_op("mulhu_ff",      3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE);
        run_op("mulh_ff",       3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000);
        run_op("mulhsu_m1",     3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF);
        run_op("mulh_min",      3'b001, 32'h8000_0000,  32'h8000_0000, 5'd9,  32'h4000_0000);
        run_op("mul_wrap",      3'b000, 32'h0001_0000,  32'h0001_0000, 5'd10, 32'h0000_0000);
        run_op("mul_by0",       3'b000, 32'h1234_5678,  32'd0,         5'd11, 32'h0000_0000);
        run_op("div_-7_2",      3'b100, 32'hFFFF_FFF9,  32'd2,         5'd12, 32'hFFFF_FFFD);
        run_op("rem_-7_2",      3'b110, 32'hFFFF_FFF9,  32'd2,         5'd13, 32'hFFFF_FFFF);
        run_op("divu_big",      3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h0000_0000);
        run_op("remu_big",      3'b111, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
        run_op("divu_100_7",    3'b101, 32'd100,        32'd7,         5'd16, 32'd14);
        run_op("remu_100_7",    3'b111, 32'd100,        32'd7,         5'd17, 32'd2);
        run_op("div_5_0",       3'b100, 32'd5,          32'd0,         5'd18, 32'hFFFF_FFFF);
        run_op("remu_5_0",      3'b111, 32'd5,          32'd0,         5'd19, 32'd5);
        run_op("div_-7_0",      3'b100, 32'hFFFF_FFF9,  32'd0,         5'd20, 32'hFFFF_FFFF);
        run_op("rem_-7_0",      3'b110, 32'hFFFF_FFF9,  32'd0,         5'd21, 32'hFFFF_FFF9);
        run_op("div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd22, 32'h8000_0000);
        run_op("rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd23, 32'h0000_0000);

        // abort a divide with reset; a second start mid-operation must be ignored
        saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd3;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            start = (i == 9);
            if (i == 9) begin rs1 = 32'd50; rs2 = 32'd5; rd_in = 5'd4; funct3 = 3'b000; end
            if (done) saw_done = 1'b1;
        end
        start = 1'b0;
        check("abort_no_early_done", {31'd0, saw_done}, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("abort_result", result, 32'd0);
        check("abort_rd_out", {27'd0, rd_out}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        run_op("post_reset_div", 3'b100, 32'd100, 32'hFFFF_FFF9, 5'd25, 32'hFFFF_FFF2);
        run_op("post_reset_mul", 3'b000, 32'd123,  32'd456,      5'd26, 32'd56088);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
